dff_bank_arbiter: RTL and testbench

//  Round-robin arbiter sharing one WIDTH-bit D-flip-flop register (q/qbar pair)

---
 rtl/dff_bank_arbiter_if.sv | 16 +
 rtl/dff_bank_arbiter.sv | 78 +++++++
 tb/tb_dff_bank_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if: requester/arbiter bundle for the shared register arbiter.
interface dff_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [OW-1:0]          owner;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qbar;
  modport master (output req, wdata, input gnt, owner, busy, q, qbar);
  modport slave  (input req, wdata, output gnt, owner, busy, q, qbar);
endinterface

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter sharing one register among requesters with a hold limit.
module dff_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  dff_bank_arbiter_if.slave bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d, last_q, last_d, win, idx;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             own_req;
  // Scan from farthest to nearest so the first requester after last wins.
  always_comb begin
    win = last_q;
    idx = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = OW'((int'(last_q) + k) % N_REQ);
      if (bus.req[idx]) win = idx;
    end
  end
  assign own_req = bus.req[owner_q];
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    q_d     = q_q;
    if (state_q == IDLE) begin
      if (|bus.req) begin
        state_d = GRANT;
        gnt_d   = N_REQ'(1) << win;
        owner_d = win;
        last_d  = win;
        hold_d  = '0;
      end
    end else begin
      if (own_req) begin
        q_d    = bus.wdata[owner_q*WIDTH +: WIDTH];
        hold_d = hold_q + HW'(1);
      end
      if (!own_req || hold_q == HW'(HOLD_MAX - 1)) begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(N_REQ - 1);
      hold_q  <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
    end
  end
  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == GRANT);
  assign bus.q     = q_q;
  assign bus.qbar  = ~q_q;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed and randomized checks against a grant-level reference model.
module tb_dff_bank_arbiter;
  localparam int N = 4, W = 8, H = 4;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  dff_bank_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  dff_bank_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_MAX(H)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0, busy_cnt;
  bit m_busy;
  int m_owner, m_last, m_caps;
  logic [W-1:0] m_q;
  int starts[$];
  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] wd(input int i);
    return bus.wdata[i*W +: W];
  endfunction
  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_caps = 0; m_q = '0;
  endtask
  task automatic check_all();
    chk("gnt", bus.gnt, m_busy ? (1 << m_owner) : 0);
    chk("owner", bus.owner, m_owner);
    chk("busy", bus.busy, m_busy);
    chk("q", bus.q, m_q);
    chk("qbar", bus.qbar, 8'(~m_q));
  endtask
  // Reference: an owner keeps the register for at most H captures, then yields.
  task automatic step();
    @(posedge clk);
    if (m_busy) begin
      if (bus.req[m_owner]) begin
        m_q = wd(m_owner);
        m_caps++;
        if (m_caps == H) m_busy = 0;
      end else m_busy = 0;
    end else if (bus.req != 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (bus.req[i]) begin
          m_owner = i; m_last = i; m_caps = 0; m_busy = 1;
          starts.push_back(i);
          break;
        end
      end
    end
    #1 check_all();
  endtask
  task automatic rst_pulse();
    #2 rst = 1;
    m_reset();
    #1 check_all();
    #2 rst = 0;
  endtask
  initial begin
    bus.req = '0;
    bus.wdata = '0;
    m_reset();
    #1 check_all();
    chk("rst_qbar", bus.qbar, 8'hFF);
    #2 rst = 0;
    repeat (10) step();
    chk("idle_q", bus.q, 0);
    chk("idle_gnt", bus.gnt, 0);
    bus.req = 4'b0010;
    bus.wdata = 32'h0000A500;
    step();
    chk("t2_gnt", bus.gnt, 4'b0010);
    step();
    chk("t2_q", bus.q, 8'hA5);
    chk("t2_qbar", bus.qbar, 8'h5A);
    bus.req = '0;
    repeat (2) step();
    rst_pulse();
    starts.delete();
    bus.req = '1;
    bus.wdata = 32'h44332211;
    busy_cnt = 0;
    repeat (25) begin
      step();
      busy_cnt += int'(bus.busy);
    end
    chk("t3_busy_cycles", busy_cnt, 20);
    chk("t3_nstarts", starts.size(), 5);
    if (starts.size() >= 5) for (int i = 0; i < 5; i++) chk("t3_order", starts[i], i % N);
    rst_pulse();
    bus.req = 4'b0001;
    bus.wdata = 32'h00000011;
    step();
    bus.wdata = 32'h00000012;
    step();
    bus.wdata = 32'h00000013;
    step();
    bus.req = 4'b0010;
    bus.wdata = 32'h00000077;
    step();
    chk("t4_gnt_drop", bus.gnt, 0);
    chk("t4_q_hold", bus.q, 8'h13);
    step();
    chk("t4_next_owner", bus.owner, 1);
    chk("t4_next_gnt", bus.gnt, 4'b0010);
    rst_pulse();
    bus.req = 4'b0100;
    bus.wdata = 32'h00C30000;
    repeat (2) step();
    chk("t5_q_pre", bus.q, 8'hC3);
    #3 rst = 1;
    m_reset();
    #1 check_all();
    chk("t5_q_async", bus.q, 0);
    chk("t5_busy_async", bus.busy, 0);
    @(negedge clk) rst = 0;
    bus.req = '1;
    step();
    chk("t5_first", bus.owner, 0);
    rst_pulse();
    bus.req = 4'b0100;
    step();
    bus.req = '0;
    step();
    bus.req = 4'b1100;
    bus.wdata = 32'h99880000;
    step();
    chk("t6_owner3", bus.owner, 3);
    repeat (5) step();
    chk("t6_owner2", bus.owner, 2);
    chk("t6_gnt2", bus.gnt, 4'b0100);
    rst_pulse();
    repeat (400) begin
      bus.req = 4'($urandom);
      bus.wdata = $urandom;
      if ($urandom_range(0, 2) == 0) bus.req = '1;
      if ($urandom_range(0, 59) == 0) rst_pulse();
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
